// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that shares one SPI transmit path among NREQ word sources.
// One 32-bit word is granted at a time. The arbiter pulses `send`, then waits for
// the transmitter to raise and drop `busy` before it grants again.
module spi_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [32*NREQ-1:0]                req_data,
    input  logic [4*NREQ-1:0]                 req_mask,
    output logic [NREQ-1:0]                   req_ready,
    input  logic                              abort,
    output logic                              send,
    output logic [31:0]                       send_data,
    output logic [3:0]                        send_valid,
    input  logic                              busy,
    output logic                              active,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                              timeout_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   rr_ptr, rr_ptr_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NREQ-1:0] req_ready_d;
    logic            send_d;
    logic [31:0]     send_data_d;
    logic [3:0]      send_valid_d;
    logic [IW-1:0]   grant_id_d;
    logic            active_d;
    logic            timeout_err_d;

    logic [NREQ-1:0] cand;
    logic            found;
    logic [IW-1:0]   win;
    logic [31:0]     win_data;
    logic [3:0]      win_mask;
    int unsigned     idx;

    // Registers for state, pointer, timeout counter and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            req_ready   <= '0;
            send        <= 1'b0;
            send_data   <= '0;
            send_valid  <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            cnt         <= cnt_d;
            req_ready   <= req_ready_d;
            send        <= send_d;
            send_data   <= send_data_d;
            send_valid  <= send_valid_d;
            grant_id    <= grant_id_d;
            active      <= active_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Round-robin winner search starting at rr_ptr. A requester whose ready pulse
    // is currently out is excluded so a just-discarded zero-mask word is not re-granted.
    always_comb begin
        cand     = req_valid & ~req_ready;
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        win_mask = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!found && cand[idx]) begin
                found    = 1'b1;
                win      = IW'(idx);
                win_data = req_data[32*idx +: 32];
                win_mask = req_mask[4*idx +: 4];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        cnt_d         = cnt;
        req_ready_d   = '0;
        send_d        = 1'b0;
        send_data_d   = send_data;
        send_valid_d  = send_valid;
        grant_id_d    = grant_id;
        timeout_err_d = timeout_err;

        case (state)
            IDLE: begin
                if (!busy && !abort && found) begin
                    send_data_d  = win_data;
                    send_valid_d = win_mask;
                    grant_id_d   = win;
                    req_ready_d  = NREQ'(1) << win;
                    rr_ptr_d     = IW'((32'(win) + 1) % NREQ);
                    if (win_mask != 4'b0000) begin
                        send_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (abort || !busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d != IDLE);
    end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares the single SPI transmit path (`send`/`send_data`/`send_valid`/`busy`) among NREQ requesters, e.g. ID reply, metadata stream, dataIn reply and sample readback.
- Sequences one 32-bit word at a time:
  - round-robin grant;
  - issues a one-cycle `send` pulse;
  - waits for the transmitter to start and finish before granting again.
- Sits between the query/readback sources and the SPI transmitter inside the SPI slave.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, max cycles to wait for `busy` to rise after `send` before giving up.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i holds a word to send.
- req_data  in  32*NREQ  word of requester i, bits [32i+31:32i].
- req_mask  in  4*NREQ  byte-valid mask of requester i, bits [4i+3:4i].
- req_ready  out  NREQ  one-cycle pulse: word i taken.
- abort  in  1  synchronised `cs_n` high or flush: drop current transfer.
- send  out  1  one-cycle transmit strobe.
- send_data  out  32  word to transmitter.
- send_valid  out  4  byte mask to transmitter.
- busy  in  1  transmitter busy.
- active  out  1  arbiter not in IDLE.
- grant_id  out  clog2(NREQ)  index of last/current grant.
- timeout_err  out  1  sticky: `busy` never rose within BUSY_TIMEOUT.

Behaviour:
- Reset (async, rst_n low) clears all of the following:
  - state=IDLE, rr_ptr=0;
  - `req_ready`=0, `send`=0, `send_data`=0, `send_valid`=0;
  - `grant_id`=0, `active`=0, `timeout_err`=0, timeout counter=0.
- Reset mid-transfer takes effect immediately. No `req_ready` or `send` is issued afterwards for the dropped word.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE:
  - Stays in IDLE while `busy` is high or `abort` is high.
  - Otherwise, if any `req_valid` is set, the winner w is the first valid index at or above rr_ptr, wrapping modulo NREQ.
  - On that edge: latch `send_data`/`send_valid` from w; set `grant_id`=w; set `req_ready[w]`=1; set rr_ptr=(w+1) mod NREQ.
  - If the mask of w is nonzero, go to ISSUE with `send`=1. The `send` pulse and the `req_ready` pulse are in the same cycle.
  - If the mask is 4'b0000, `req_ready[w]` still pulses, no `send` is issued, and the state stays IDLE. The word is discarded.
- ISSUE (1 cycle): `send` and `req_ready` return to 0 on exit. Clear the timeout counter and go to WAIT_START.
- WAIT_START:
  - `busy`=1 → WAIT_DONE.
  - Otherwise the counter increments.
  - When the counter reaches BUSY_TIMEOUT-1 with `busy` still 0: set `timeout_err`=1 and go to IDLE.
- WAIT_DONE: `busy`=0 → IDLE.
- `abort`=1 in WAIT_START or WAIT_DONE forces the next state to IDLE. The word is already acknowledged and is not retried.
- `abort` in ISSUE is ignored for that cycle; it acts in WAIT_START.
- Requester contract: hold `req_valid`/`data`/`mask` stable until `req_ready[i]` is seen. `req_ready[i]` is registered, asserted in the cycle after the grant edge, and lasts exactly one cycle.
- Minimum spacing between two `send` pulses: ISSUE + WAIT_START + WAIT_DONE + IDLE = 4 cycles plus transmitter busy time.
- At most one `req_ready` bit is high in any cycle.
- `active` = (state != IDLE).
- `send_data`/`send_valid` hold their value until the next grant.
- `timeout_err` clears only on reset.
- Simultaneous events:
  - `req_valid` rising in the same cycle as returning to IDLE is evaluated in the next IDLE cycle. IDLE always takes ≥1 cycle.
  - With all requesters valid, grants rotate 0,1,2,3,0…
  - A requester dropping `req_valid` before grant is simply skipped.

Test Plan:
- Single request, with req 2 valid, data=32'hA5A5_1234, mask=4'hF, and transmitter `busy` rising 2 cycles after `send` for 10 cycles:
  - one `send` pulse with `send_data`=32'hA5A5_1234, `send_valid`=4'hF;
  - `req_ready`=4'b0100 for exactly 1 cycle, in the same cycle as `send`;
  - `grant_id`=2;
  - `active` falls 1 cycle after `busy` falls.
- Fairness, with all 4 valid continuously for 8 words: grant order is 0,1,2,3,0,1,2,3, and no two `send` pulses are closer than 4 cycles.
- Zero mask, with req 1 mask=4'b0000: `req_ready[1]` pulses, `send` stays 0, the state stays IDLE, and the next requester is served on the following IDLE cycle.
- Timeout, with `busy` held 0 after `send` and BUSY_TIMEOUT=16: `timeout_err` rises 16 cycles after ISSUE, the arbiter returns to IDLE, and the next pending request is granted.
- Abort, with `abort` pulsed during WAIT_DONE while `busy`=1: the arbiter returns to IDLE and does not grant while `busy` remains 1. It grants after `busy` falls, with no duplicate `req_ready` for the aborted word.
- Reset: drive rst_n low during WAIT_START. All outputs go to 0 asynchronously, rr_ptr=0, and after release the first grant goes to the lowest valid index.
